reg_cmd_sequencer: RTL and testbench

Control-path sequencer that sits directly upstream of the in-band register access block. It accepts decoded register read/write commands from the command-packet reader, drives the register block's `enable`/`addr`/`datain` bus with one-cycle accesses, and captures read results (`dataout`). It returns those results through a single-entry reply buffer with valid/ready backpressure toward the response-packet builder.

---
 rtl/reg_cmd_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_reg_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// reg_cmd_sequencer
//
// Sits between the command-packet reader and the in-band register access
// block. It takes one decoded read/write command at a time and issues a
// single one-cycle access on the register bus (enable/addr/datain). Read
// results (dataout) go into a single-entry reply buffer that the
// response-packet builder drains with a valid/ready handshake.
//
// Optional feature macro: REG_CMD_SEQ_WRITE_ACK_EN
//   defined   : writes also produce a reply (rsp_data = written data)
//   undefined : writes complete silently (default build)
//
// Parameters
//   ADDR_MAX   highest valid register address; reads above it are flagged
//              through rsp_err but are still issued
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   cmd_*      command input (valid/ready, rd, addr, data, rid)
//   enable     register bus: bit1 = access active, bit0 = read(1)/write(0)
//   addr       register bus address
//   datain     register bus write data
//   dataout    register bus read data (combinational, same cycle as a read)
//   rsp_*      reply output (valid/ready, rid, addr, data, err)
//   rd_count   completed reads, wraps modulo 2^16
//   wr_count   completed writes, wraps modulo 2^16
//   debugbus   {state, enable, cmd_valid, cmd_ready, rsp_valid, rsp_ready,
//               addr, 1'b0}
// -----------------------------------------------------------------------------
module reg_cmd_sequencer #(
  parameter int unsigned ADDR_MAX = 43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [5:0]  cmd_rid,
  output logic [1:0]  enable,
  output logic [6:0]  addr,
  output logic [31:0] datain,
  input  logic [31:0] dataout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_rid,
  output logic [6:0]  rsp_addr,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] debugbus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        cmd_ready_r;
  logic [1:0]  enable_r;
  logic [6:0]  addr_r;      // doubles as the held command address
  logic [31:0] datain_r;    // doubles as the held command write data
  logic [5:0]  rid_r;
  logic        rsp_valid_r;
  logic [5:0]  rsp_rid_r;
  logic [6:0]  rsp_addr_r;
  logic [31:0] rsp_data_r;
  logic        rsp_err_r;
  logic [15:0] rd_count_r;
  logic [15:0] wr_count_r;

  // True when an address lies beyond the implemented register range.
  function automatic logic addr_out_of_range(input logic [6:0] a);
    return ({25'd0, a} > 32'(ADDR_MAX));
  endfunction

  // Command sequencing FSM with all bus, reply and counter registers.
  // cmd_ready_r is updated together with state_r so it always equals
  // (state_r == ST_IDLE) while still coming straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      enable_r    <= 2'b00;
      addr_r      <= 7'd0;
      datain_r    <= 32'd0;
      rid_r       <= 6'd0;
      rsp_valid_r <= 1'b0;
      rsp_rid_r   <= 6'd0;
      rsp_addr_r  <= 7'd0;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= 1'b0;
      rd_count_r  <= 16'd0;
      wr_count_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r      <= cmd_addr;
            datain_r    <= cmd_data;
            rid_r       <= cmd_rid;
            cmd_ready_r <= 1'b0;
            if (cmd_rd) begin
              state_r  <= ST_RD;
              enable_r <= 2'b11;
            end else begin
              state_r  <= ST_WR;
              enable_r <= 2'b10;
            end
          end
        end

        ST_WR: begin
          enable_r   <= 2'b00;
          wr_count_r <= wr_count_r + 16'd1;
`ifdef REG_CMD_SEQ_WRITE_ACK_EN
          rsp_data_r  <= datain_r;
          rsp_addr_r  <= addr_r;
          rsp_rid_r   <= rid_r;
          rsp_err_r   <= addr_out_of_range(addr_r);
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RSP;
`else
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
`endif
        end

        ST_RD: begin
          // dataout is combinational from the register block and valid now.
          enable_r    <= 2'b00;
          rsp_data_r  <= dataout;
          rsp_addr_r  <= addr_r;
          rsp_rid_r   <= rid_r;
          rsp_err_r   <= addr_out_of_range(addr_r);
          rsp_valid_r <= 1'b1;
          rd_count_r  <= rd_count_r + 16'd1;
          state_r     <= ST_RSP;
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          enable_r    <= 2'b00;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign enable    = enable_r;
  assign addr      = addr_r;
  assign datain    = datain_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rid   = rsp_rid_r;
  assign rsp_addr  = rsp_addr_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign rd_count  = rd_count_r;
  assign wr_count  = wr_count_r;

  // The named fields already occupy 15 bits, so the low pad is a single
  // zero bit to keep the word at 16 bits.
  assign debugbus = {state_r, enable_r, cmd_valid, cmd_ready_r,
                     rsp_valid_r, rsp_ready, addr_r, 1'b0};

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
module tb_reg_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [5:0]  cmd_rid;
  logic [1:0]  enable;
  logic [6:0]  addr;
  logic [31:0] datain, dataout;
  logic        rsp_valid, rsp_ready;
  logic [5:0]  rsp_rid;
  logic [6:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] rd_count, wr_count, debugbus;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] exp_wr = 16'd0;

  reg_cmd_sequencer #(.ADDR_MAX(43)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rid(cmd_rid),
    .enable(enable), .addr(addr), .datain(datain), .dataout(dataout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rid(rsp_rid),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rd_count(rd_count), .wr_count(wr_count), .debugbus(debugbus)
  );

  always #5 clk = ~clk;

  // Register-block model: fixed contents, all-ones above address 43.
  function automatic logic [31:0] reg_val(input logic [6:0] a);
    if (a > 7'd43) return 32'hFFFF_FFFF;
    else if (a == 7'd2) return 32'h0000_0ABC;
    else return {16'hC0DE, 9'd0, a};
  endfunction

  always_comb dataout = (enable == 2'b11) ? reg_val(addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input logic rd, input logic [6:0] a, input logic [31:0] d, input logic [5:0] rid);
    cmd_rd = rd; cmd_addr = a; cmd_data = d; cmd_rid = rid;
  endtask

  typedef struct {
    logic        rd;
    logic [6:0]  a;
    logic [31:0] d;
    logic [5:0]  rid;
    logic [1:0]  exp_en;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct { logic [1:0] en; logic [6:0] a; logic [31:0] d; } acc_t;
  typedef struct { logic [5:0] rid; logic [6:0] a; logic [31:0] d; logic err; } rep_t;

  acc_t acc_q[$];
  rep_t rep_q[$];

  // Random-phase observer: compares accesses and replies against queued
  // expectations and records newly accepted commands.
  task automatic rnd_observe();
    acc_t ea;
    rep_t er;
    if (enable != 2'b00) begin
      if (acc_q.size() == 0) chk("rnd_spurious_access", 32'(enable), 32'd0);
      else begin
        ea = acc_q.pop_front();
        chk("rnd_enable", 32'(enable), 32'(ea.en));
        chk("rnd_addr", 32'(addr), 32'(ea.a));
        if (ea.en == 2'b10) chk("rnd_datain", datain, ea.d);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rep_q.size() == 0) chk("rnd_spurious_reply", 32'(rsp_valid), 32'd0);
      else begin
        er = rep_q.pop_front();
        chk("rnd_rsp_rid", 32'(rsp_rid), 32'(er.rid));
        chk("rnd_rsp_addr", 32'(rsp_addr), 32'(er.a));
        chk("rnd_rsp_data", rsp_data, er.d);
        chk("rnd_rsp_err", 32'(rsp_err), 32'(er.err));
      end
    end
    if (rsp_valid && cmd_ready) chk("rnd_ready_while_valid", 32'(cmd_ready), 32'd0);
    if (cmd_valid && cmd_ready) begin
      acc_q.push_back('{en: cmd_rd ? 2'b11 : 2'b10, a: cmd_addr, d: cmd_data});
      if (cmd_rd) begin
        rep_q.push_back('{rid: cmd_rid, a: cmd_addr, d: reg_val(cmd_addr), err: (cmd_addr > 7'd43)});
        exp_rd = exp_rd + 16'd1;
      end else begin
        exp_wr = exp_wr + 16'd1;
      end
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [1:0] seen[$];
    logic [1:0] b2b_exp[3];
    int idx;
    int acc;

    vecs[0] = '{1'b0, 7'd9,  32'h0000_1234, 6'd1,  2'b10, 32'd0,          1'b0};
    vecs[1] = '{1'b1, 7'd2,  32'h0,         6'd5,  2'b11, 32'h0000_0ABC,  1'b0};
    vecs[2] = '{1'b1, 7'd50, 32'h0,         6'd7,  2'b11, 32'hFFFF_FFFF,  1'b1};
    vecs[3] = '{1'b1, 7'd43, 32'h0,         6'd63, 2'b11, 32'hC0DE_002B,  1'b0};
    vecs[4] = '{1'b1, 7'd44, 32'h0,         6'd0,  2'b11, 32'hFFFF_FFFF,  1'b1};
    vecs[5] = '{1'b0, 7'd60, 32'hA5A5_5A5A, 6'd2,  2'b10, 32'd0,          1'b0};
    vecs[6] = '{1'b1, 7'd0,  32'h0,         6'd12, 2'b11, 32'hC0DE_0000,  1'b0};
    b2b_exp[0] = 2'b10; b2b_exp[1] = 2'b11; b2b_exp[2] = 2'b10;

    // Reset state
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    set_cmd(1'b0, 7'd0, 32'd0, 6'd0);
    @(negedge clk); @(negedge clk);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_datain", datain, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fields", {rsp_rid, rsp_addr, rsp_err, 18'd0}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_counts", {rd_count, wr_count}, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b1;

    // Table-driven single commands
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_cmd(vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].rid);
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      chk("vec_accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("vec_enable", 32'(enable), 32'(vecs[i].exp_en));
      chk("vec_addr", 32'(addr), 32'(vecs[i].a));
      if (!vecs[i].rd) chk("vec_datain", datain, vecs[i].d);
      @(negedge clk);
      chk("vec_enable_off", 32'(enable), 32'd0);
      if (vecs[i].rd) begin
        exp_rd = exp_rd + 16'd1;
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_busy", 32'(cmd_ready), 32'd0);
        chk("vec_rsp_data", rsp_data, vecs[i].exp_data);
        chk("vec_rsp_rid", 32'(rsp_rid), 32'(vecs[i].rid));
        chk("vec_rsp_addr", 32'(rsp_addr), 32'(vecs[i].a));
        chk("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].exp_err));
        chk("vec_rd_count", 32'(rd_count), 32'(exp_rd));
        @(negedge clk);
        chk("vec_ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("vec_rsp_taken", 32'(rsp_valid), 32'd0);
      end else begin
        exp_wr = exp_wr + 16'd1;
        chk("vec_wr_ready", 32'(cmd_ready), 32'd1);
        chk("vec_wr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("vec_wr_count", 32'(wr_count), 32'(exp_wr));
      end
    end

    // Reply stalled 10 cycles with the next command already waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(1'b1, 7'd5, 32'h1357_9BDF, 6'd33);
    @(negedge clk);
    chk("stall_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    set_cmd(1'b0, 7'd7, 32'hCAFE_F00D, 6'd1);
    @(negedge clk);
    chk("stall_rd_enable", 32'(enable), 32'd3);
    chk("stall_busy_rd", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, 32'hC0DE_0005);
      chk("stall_rsp_id", {rsp_rid, rsp_addr, rsp_err}, {6'd33, 7'd5, 1'b0});
      chk("stall_enable", 32'(enable), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("stall_next_accept", 32'(cmd_ready & cmd_valid), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("stall_next_enable", 32'(enable), 32'd2);
    chk("stall_next_addr", 32'(addr), 32'd7);
    chk("stall_next_datain", datain, 32'hCAFE_F00D);
    exp_rd = exp_rd + 16'd1; exp_wr = exp_wr + 16'd1;

    // Back-to-back write, read, write with cmd_valid held
    @(posedge clk); #1;
    idx = 0;
    set_cmd(1'b0, 7'd10, 32'h0000_1111, 6'd3);
    cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (enable != 2'b00) seen.push_back(enable);
      if (cmd_valid && cmd_ready) idx++;
      @(posedge clk); #1;
      if (idx == 1) set_cmd(1'b1, 7'd11, 32'h0, 6'd9);
      else if (idx == 2) set_cmd(1'b0, 7'd12, 32'h0000_2222, 6'd4);
      else if (idx >= 3) cmd_valid = 1'b0;
    end
    chk("b2b_access_count", 32'(seen.size()), 32'd3);
    for (int j = 0; j < 3; j++)
      if (j < seen.size()) chk("b2b_enable_order", 32'(seen[j]), 32'(b2b_exp[j]));
    exp_wr = exp_wr + 16'd2; exp_rd = exp_rd + 16'd1;
    chk("b2b_counts", {rd_count, wr_count}, {exp_rd, exp_wr});

    // Randomized traffic against the queue model
    acc_q.delete(); rep_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rnd_observe();
      @(posedge clk); #1;
      if ((cmd_valid && cmd_ready) || !cmd_valid) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        set_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 63)), $urandom, 6'($urandom_range(0, 63)));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    // the command just presented is dropped only if it was never accepted
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rnd_observe();
    end
    chk("rnd_acc_drained", 32'(acc_q.size()), 32'd0);
    chk("rnd_rep_drained", 32'(rep_q.size()), 32'd0);
    chk("rnd_counts", {rd_count, wr_count}, {exp_rd, exp_wr});

    // Reset asserted during a read access
    @(posedge clk); #1;
    set_cmd(1'b1, 7'd4, 32'h0, 6'd8); cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstrd_in_rd", 32'(enable), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("rstrd_enable", 32'(enable), 32'd0);
    chk("rstrd_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    exp_rd = 16'd0; exp_wr = 16'd0;
    @(negedge clk); @(negedge clk);
    chk("rstrd_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstrd_no_reply", 32'(rsp_valid), 32'd0);
    chk("rstrd_counts", {rd_count, wr_count}, 32'd0);

    // Write counter preload to 0xFFFF and wrap
    @(posedge clk); #1;
    set_cmd(1'b0, 7'd3, 32'h0000_00AA, 6'd0); cmd_valid = 1'b1;
    acc = 0;
    for (int g = 0; g < 140000; g++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      @(posedge clk); #1;
      if (acc == 65535) begin
        cmd_valid = 1'b0;
        break;
      end
    end
    chk("wrap_preload_accepts", 32'(acc), 32'd65535);
    @(negedge clk); @(negedge clk);
    chk("wrap_at_ffff", 32'(wr_count), 32'h0000_FFFF);
    @(posedge clk); #1 cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("wrap_to_zero", 32'(wr_count), 32'd0);
    chk("wrap_rd_untouched", 32'(rd_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
